// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the memory stage to a valid/ready data bus with byte strobes.
// Define LSU_MISALIGN_SPLIT_EN to allow misaligned accesses (split into two beats when crossing 8 bytes).
module lsu_mem_bridge #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
`ifdef LSU_MISALIGN_SPLIT_EN
    REQ1,
    WAIT1,
`endif
    RESP
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic [2:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [63:0]       mem_wdata_q;
  logic [7:0]        mem_wstrb_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [63:0]       resp_rdata_q;

  logic [7:0]        bmask_d;
  logic [2:0]        off_d;
  logic              reject_d;
  logic [127:0]      ld_beats_d;
  logic [63:0]       ld_data_d;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [3:0]        nbytes_d;
  logic              cross_d;
  logic [15:0]       strb_d;
  logic [127:0]      wdata_d;
  logic              split_q;
  logic [7:0]        wstrb_hi_q;
  logic [63:0]       wdata_hi_q;
  logic [63:0]       beat0_q;
`else
  logic              mis_d;
  logic [7:0]        strb_d;
  logic [63:0]       wdata_d;
`endif

  // Right-align the addressed bytes, then sign/zero extend from the access size.
  function automatic logic [63:0] extend(input logic [127:0] beats, input logic [2:0] off,
                                         input logic [1:0] size, input logic uns);
    logic [63:0] x;
    x = 64'(beats >> {off, 3'b000});
    case (size)
      2'd0:    extend = uns ? {56'h0, x[7:0]}  : {{56{x[7]}}, x[7:0]};
      2'd1:    extend = uns ? {48'h0, x[15:0]} : {{48{x[15]}}, x[15:0]};
      2'd2:    extend = uns ? {32'h0, x[31:0]} : {{32{x[31]}}, x[31:0]};
      default: extend = x;
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bmask_d = 8'h00;
    case (req_size)
      2'd0:    bmask_d = 8'h01;
      2'd1:    bmask_d = 8'h03;
      2'd2:    bmask_d = 8'h0F;
      default: bmask_d = 8'hFF;
    endcase
    off_d = req_addr[2:0];
`ifdef LSU_MISALIGN_SPLIT_EN
    nbytes_d = 4'd1 << req_size;
    cross_d  = ({1'b0, off_d} + nbytes_d) > 4'd8;
    strb_d   = {8'h00, bmask_d} << off_d;
    wdata_d  = {64'h0, req_wdata} << {off_d, 3'b000};
    reject_d = 1'b0;
    ld_beats_d = (state_q == WAIT1) ? {mem_rdata, beat0_q} : {64'h0, mem_rdata};
`else
    case (req_size)
      2'd0:    mis_d = 1'b0;
      2'd1:    mis_d = req_addr[0];
      2'd2:    mis_d = |req_addr[1:0];
      default: mis_d = |req_addr[2:0];
    endcase
    strb_d   = bmask_d << off_d;
    wdata_d  = req_wdata << {off_d, 3'b000};
    reject_d = mis_d;
    ld_beats_d = {64'h0, mem_rdata};
`endif
    ld_data_d = extend(ld_beats_d, off_q, size_q, uns_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      off_q           <= 3'd0;
      size_q          <= 2'd0;
      uns_q           <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= 1'b0;
      mem_wdata_q     <= 64'h0;
      mem_wstrb_q     <= 8'h00;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= 64'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q         <= 1'b0;
      wstrb_hi_q      <= 8'h00;
      wdata_hi_q      <= 64'h0;
      beat0_q         <= 64'h0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q   <= req_we;
          off_q  <= off_d;
          size_q <= req_size;
          uns_q  <= req_unsigned;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_q    <= cross_d;
          wstrb_hi_q <= strb_d[15:8];
          wdata_hi_q <= wdata_d[127:64];
`endif
          if (reject_d) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 64'h0;
            state_q      <= RESP;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= {req_addr[ADDR_W-1:3], 3'b000};
            mem_we_q        <= req_we;
            mem_wstrb_q     <= strb_d[7:0];
            mem_wdata_q     <= wdata_d[63:0];
            state_q         <= REQ0;
          end
        end
        REQ0: if (mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          state_q         <= WAIT0;
        end
        WAIT0: if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            beat0_q         <= mem_rdata;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= mem_addr_q + ADDR_W'(8);
            mem_wstrb_q     <= wstrb_hi_q;
            mem_wdata_q     <= wdata_hi_q;
            state_q         <= REQ1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 64'h0 : ld_data_d;
            state_q      <= RESP;
          end
`else
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 64'h0 : ld_data_d;
          state_q      <= RESP;
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        REQ1: if (mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          state_q         <= WAIT1;
        end
        WAIT1: if (mem_rvalid) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 64'h0 : ld_data_d;
          state_q      <= RESP;
        end
`endif
        RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 64'h0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;

endmodule
